// File: rtl/xin_rom_sequencer_pkg.sv
// Shared XIN ROM sequencer definitions: default geometry and FSM state encoding.
package tm_xin_pkg;
    localparam int XIN_DATA_W      = 32;
    localparam int XIN_ADDR_W      = 6;
    localparam int XIN_DEPTH       = 49;
    localparam int XIN_NUM_SAMPLES = 10;
    localparam int XIN_SAMPLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } xin_state_e;
endpackage

// File: rtl/xin_rom_sequencer_if.sv
// Control, ROM-side and beat-side signals of the XIN ROM sequencer.
interface xin_rom_sequencer_if
    import tm_xin_pkg::*;
#(
    parameter int DATA_WIDTH = XIN_DATA_W,
    parameter int ADDR_WIDTH = XIN_ADDR_W,
    parameter int SAMPLE_W   = XIN_SAMPLE_W
) ();
    logic                  start;
    logic [SAMPLE_W-1:0]   sample_sel;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [SAMPLE_W-1:0]   rom_sample;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_index;
    logic                  out_last;

    modport slave (
        input  start, sample_sel, abort, rom_data, out_ready,
        output busy, done, err, rom_sample, rom_addr,
               out_valid, out_data, out_index, out_last
    );

    modport master (
        output start, sample_sel, abort, rom_data, out_ready,
        input  busy, done, err, rom_sample, rom_addr,
               out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/xin_rom_sequencer_out_reg.sv
// Single-entry valid/ready output register; payload holds while stalled.
module xin_out_reg
    import tm_xin_pkg::*;
#(
    parameter int DATA_WIDTH = XIN_DATA_W,
    parameter int ADDR_WIDTH = XIN_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  flush_i,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_WIDTH-1:0] index_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [ADDR_WIDTH-1:0] index_o,
    output logic                  last_o
);
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            if (flush_i)      valid_q <= 1'b0;
            else if (load_i)  valid_q <= 1'b1;
            else if (ready_i) valid_q <= 1'b0;
            // payload only moves on load, so it is stable under stall and after drain
            if (load_i) begin
                data_q  <= data_i;
                index_q <= index_i;
                last_q  <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign index_o = index_q;
    assign last_o  = last_q;
endmodule

// File: rtl/xin_rom_sequencer.sv
// Streams one sample out of the XIN ROM bank: sample select, address walk, completion.
module xin_rom_sequencer
    import tm_xin_pkg::*;
#(
    parameter int DATA_WIDTH  = XIN_DATA_W,
    parameter int ADDR_WIDTH  = XIN_ADDR_W,
    parameter int ROM_DEPTH   = XIN_DEPTH,
    parameter int NUM_SAMPLES = XIN_NUM_SAMPLES,
    parameter int SAMPLE_W    = XIN_SAMPLE_W
) (
    input logic               clk,
    input logic               rst,
    xin_rom_sequencer_if.slave bus
);
    // one extra bit so rd_addr can rest at ROM_DEPTH even when ROM_DEPTH == 2**ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(ROM_DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_C  = (ADDR_WIDTH+1)'(ROM_DEPTH - 1);
    localparam logic [SAMPLE_W:0]   NSAMP_C = (SAMPLE_W+1)'(NUM_SAMPLES);

    xin_state_e            state_q, state_d;
    logic [ADDR_WIDTH:0]   rd_addr_q, rd_addr_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  err_q, err_d;

    logic                  out_valid, out_last;
    logic                  in_stream, load, flush, sel_ok;

    assign in_stream = (state_q == STREAM);
    assign sel_ok    = ({1'b0, bus.sample_sel} < NSAMP_C);
    assign flush     = in_stream & bus.abort;
    assign load      = in_stream & ~bus.abort & (~out_valid | bus.out_ready)
                     & (rd_addr_q < DEPTH_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            sample_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            sample_q  <= sample_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        sample_d  = sample_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // abort in the same cycle suppresses the start entirely
                if (bus.start && !bus.abort) begin
                    if (sel_ok) begin
                        state_d   = STREAM;
                        sample_d  = bus.sample_sel;
                        rd_addr_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    if (load) rd_addr_d = rd_addr_q + (ADDR_WIDTH+1)'(1);
                    if (out_valid && bus.out_ready && out_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    xin_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .flush_i (flush),
        .ready_i (bus.out_ready),
        .data_i  (bus.rom_data),
        .index_i (rd_addr_q[ADDR_WIDTH-1:0]),
        .last_i  (rd_addr_q == LAST_C),
        .valid_o (out_valid),
        .data_o  (bus.out_data),
        .index_o (bus.out_index),
        .last_o  (out_last)
    );

    assign bus.out_valid  = out_valid;
    assign bus.out_last   = out_last;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.err        = err_q;
    assign bus.rom_sample = sample_q;
    assign bus.rom_addr   = (rd_addr_q >= DEPTH_C) ? LAST_C[ADDR_WIDTH-1:0]
                                                   : rd_addr_q[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_xin_rom_sequencer.sv
// Scoreboard bench for xin_rom_sequencer against an address-encoding ROM model.
module tb_xin_rom_sequencer;
    import tm_xin_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 49;
    localparam int SW    = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xin_rom_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_W(SW)) bus ();

    xin_rom_sequencer #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .ROM_DEPTH   (DEPTH),
        .NUM_SAMPLES (10),
        .SAMPLE_W    (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_data = 32'hA500_0000 | (32'(bus.rom_sample) << 16) | 32'(bus.rom_addr);

    beat_t exp_q[$];
    beat_t mb;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, acc_cnt = 0, done_cnt = 0, stall_cnt = 0, last_cyc = -100;
    int rdy_mode = 0, stall_left = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [SW-1:0] sel);
        beat_t b;
        for (int k = 0; k < DEPTH; k++) begin
            b.data = 32'hA500_0000 | (32'(sel) << 16) | 32'(k);
            b.idx  = AW'(k);
            b.last = (k == DEPTH - 1);
            exp_q.push_back(b);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: bus.out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (bus.out_valid && bus.out_index == AW'(10) && stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // accepted beats are popped from the scoreboard; stalled beats must match its head
    initial forever begin
        @(negedge clk);
        if (bus.done === 1'b1) done_cnt++;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                check("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                mb = exp_q.pop_front();
                check("beat_data", 64'(bus.out_data), 64'(mb.data));
                check("beat_index", 64'(bus.out_index), 64'(mb.idx));
                check("beat_last", 64'(bus.out_last), 64'(mb.last));
                if (mb.last) last_cyc = cyc;
            end
        end else if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
            stall_cnt++;
            if (exp_q.size() > 0) begin
                check("stall_data", 64'(bus.out_data), 64'(exp_q[0].data));
                check("stall_index", 64'(bus.out_index), 64'(exp_q[0].idx));
            end
        end
    end

    task automatic go(input logic [SW-1:0] sel, input bit push);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.sample_sel = sel;
        if (push) push_exp(sel);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget);
        for (int i = 0; i < budget && acc_cnt < n; i++) begin
            @(posedge clk);
            #1;
        end
        check("acc_reached", 64'(acc_cnt >= n), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        int dc   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                dc   = cyc;
                break;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("done_after_last", 64'(dc), 64'(last_cyc + 1));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            #1;
            check("done_one_cycle", 64'(bus.done), 64'd0);
            check("busy_after_done", 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_done"},  64'(bus.done), 64'd0);
        check({tag, "_err"},   64'(bus.err), 64'd0);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_data"},  64'(bus.out_data), 64'd0);
        check({tag, "_index"}, 64'(bus.out_index), 64'd0);
        check({tag, "_last"},  64'(bus.out_last), 64'd0);
        check({tag, "_raddr"}, 64'(bus.rom_addr), 64'd0);
        check({tag, "_rsamp"}, 64'(bus.rom_sample), 64'd0);
    endtask

    task automatic run_basic();
        int d0 = done_cnt;
        acc_cnt = 0;
        go(4'd3, 1'b1);
        @(negedge clk);
        check("lat_t1_valid", 64'(bus.out_valid), 64'd0);
        check("lat_t1_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        check("lat_t2_valid", 64'(bus.out_valid), 64'd1);
        check("lat_t2_index", 64'(bus.out_index), 64'd0);
        wait_done(200);
        check("basic_beats", 64'(acc_cnt), 64'd49);
        check("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.sample_sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // basic stream
        run_basic();

        // backpressure on index 10
        rdy_mode   = 2;
        stall_left = 5;
        stall_cnt  = 0;
        acc_cnt    = 0;
        go(4'd3, 1'b1);
        wait_done(300);
        check("bp_stall_cycles", 64'(stall_cnt), 64'd5);
        check("bp_beats", 64'(acc_cnt), 64'd49);
        rdy_mode = 0;

        // random ready
        rdy_mode = 1;
        acc_cnt  = 0;
        d0       = done_cnt;
        go(4'd9, 1'b1);
        wait_done(2000);
        check("rand_beats", 64'(acc_cnt), 64'd49);
        check("rand_done_cnt", 64'(done_cnt - d0), 64'd1);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // abort mid-stream, then restart on another sample
        acc_cnt = 0;
        go(4'd3, 1'b1);
        wait_acc(20, 100);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_valid", 64'(bus.out_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        acc_cnt = 0;
        go(4'd1, 1'b1);
        wait_done(200);
        check("restart_beats", 64'(acc_cnt), 64'd49);

        // invalid sample select
        acc_cnt = 0;
        go(4'd12, 1'b0);
        @(negedge clk);
        check("inv_err", 64'(bus.err), 64'd1);
        check("inv_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("inv_err_pulse", 64'(bus.err), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("inv_no_beats", 64'(acc_cnt), 64'd0);

        // start while busy is ignored
        go(4'd3, 1'b1);
        wait_acc(10, 100);
        bus.start      = 1'b1;
        bus.sample_sel = 4'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_start_sample", 64'(bus.rom_sample), 64'd3);
        check("busy_start_busy", 64'(bus.busy), 64'd1);
        wait_done(200);
        check("busy_start_beats", 64'(acc_cnt), 64'd49);

        // reset mid-stream, then a clean stream
        acc_cnt = 0;
        go(4'd3, 1'b1);
        wait_acc(30, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        run_basic();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
